// File: rtl/lfsr_pkg.sv
// Shared definitions for the 8-bit PRBS generator/checker pair.
package lfsr_pkg;

    localparam int LFSR_W = 8;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } chk_state_t;

    // Feedback tap set used by both sides of the link: s[3]^s[2]^s[1].
    function automatic logic lfsr_fb(input logic [LFSR_W-1:0] s);
        return s[3] ^ s[2] ^ s[1];
    endfunction

endpackage

// File: rtl/lfsr_chk_window.sv
// Loss-of-lock detector: counts valid bits in a fixed-size window and the
// errors seen inside it; loss_o fires on the bit that reaches the threshold.
module lfsr_chk_window #(
    parameter int WINDOW      = 64,
    parameter int LOSS_THRESH = 8
) (
    input  logic clk,
    input  logic resetn,
    input  logic clr,
    input  logic bit_valid,
    input  logic bit_err,
    output logic loss_o
);

    localparam int WIN_W  = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int ERR_CW = $clog2(LOSS_THRESH + 1);

    logic [WIN_W-1:0]  win_reg, win_next;
    logic [ERR_CW-1:0] win_err_reg, win_err_next;
    logic              wrap;

    // Next-state of the window position and in-window error count.
    always_comb begin
        win_next     = win_reg;
        win_err_next = win_err_reg;
        wrap         = (win_reg == WIN_W'(WINDOW - 1));
        if (bit_valid) begin
            win_next = wrap ? '0 : win_reg + 1'b1;
            if (wrap)
                win_err_next = bit_err ? ERR_CW'(1) : '0;
            else if (bit_err)
                win_err_next = win_err_reg + 1'b1;
        end
        loss_o = bit_valid && bit_err && (win_err_next >= ERR_CW'(LOSS_THRESH));
    end

    // Window registers; held clear whenever the checker is not locked.
    always_ff @(posedge clk) begin
        if (!resetn || clr) begin
            win_reg     <= '0;
            win_err_reg <= '0;
        end else begin
            win_reg     <= win_next;
            win_err_reg <= win_err_next;
        end
    end

endmodule

// File: rtl/lfsr_prbs_checker.sv
// Self-synchronising PRBS checker for the 8-bit LFSR stream. Hunts for a
// seed, verifies predictions, then flywheels while counting bit errors.
module lfsr_prbs_checker
    import lfsr_pkg::*;
#(
    parameter int LOCK_CNT    = 16,
    parameter int WINDOW      = 64,
    parameter int LOSS_THRESH = 8,
    parameter int ERR_W       = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             din_bit,
    input  logic             din_valid,
    input  logic             err_clr,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_cnt
);

    localparam int FILL_W  = $clog2(LFSR_W);
    localparam int MATCH_W = $clog2(LOCK_CNT + 1);

    chk_state_t         state_reg;
    logic [LFSR_W-1:0]  sr_reg;
    logic [FILL_W-1:0]  fill_reg;
    logic [MATCH_W-1:0] match_reg;
    logic               locked_reg;
    logic               err_pulse_reg;
    logic [ERR_W-1:0]   err_cnt_reg;

    logic exp_bit;
    logic mismatch;
    logic sr_zero;
    logic lock_err;
    logic loss;

    assign exp_bit  = lfsr_fb(sr_reg);
    assign mismatch = din_bit ^ exp_bit;
    assign sr_zero  = (sr_reg == '0);
    assign lock_err = din_valid && (state_reg == LOCKED) && mismatch;

    lfsr_chk_window #(
        .WINDOW      (WINDOW),
        .LOSS_THRESH (LOSS_THRESH)
    ) u_window (
        .clk       (clk),
        .resetn    (resetn),
        .clr       (state_reg != LOCKED),
        .bit_valid (din_valid && (state_reg == LOCKED)),
        .bit_err   (mismatch),
        .loss_o    (loss)
    );

    // Acquisition FSM: HUNT fills the local LFSR, VERIFY checks predictions,
    // LOCKED free-runs the local LFSR so bad bits cannot corrupt it.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg  <= HUNT;
            sr_reg     <= '0;
            fill_reg   <= '0;
            match_reg  <= '0;
            locked_reg <= 1'b0;
        end else if (din_valid) begin
            case (state_reg)
                HUNT: begin
                    sr_reg <= {sr_reg[LFSR_W-2:0], din_bit};
                    if (fill_reg == FILL_W'(LFSR_W - 1)) begin
                        fill_reg  <= '0;
                        state_reg <= VERIFY;
                    end else begin
                        fill_reg <= fill_reg + 1'b1;
                    end
                end
                VERIFY: begin
                    sr_reg <= {sr_reg[LFSR_W-2:0], din_bit};
                    // An all-zero state predicts zeros forever; never trust it.
                    if (mismatch || sr_zero) begin
                        match_reg <= '0;
                    end else if (match_reg == MATCH_W'(LOCK_CNT - 1)) begin
                        match_reg  <= MATCH_W'(LOCK_CNT);
                        state_reg  <= LOCKED;
                        locked_reg <= 1'b1;
                    end else begin
                        match_reg <= match_reg + 1'b1;
                    end
                end
                LOCKED: begin
                    if (loss) begin
                        state_reg  <= HUNT;
                        sr_reg     <= '0;
                        fill_reg   <= '0;
                        match_reg  <= '0;
                        locked_reg <= 1'b0;
                    end else begin
                        sr_reg <= {sr_reg[LFSR_W-2:0], exp_bit};
                    end
                end
                default: begin
                    state_reg  <= HUNT;
                    locked_reg <= 1'b0;
                end
            endcase
        end
    end

    // Error reporting: one-cycle pulse and saturating count; a counted
    // error beats a simultaneous clear so the new error is not lost.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            err_pulse_reg <= 1'b0;
            err_cnt_reg   <= '0;
        end else begin
            err_pulse_reg <= lock_err;
            if (lock_err) begin
                if (err_clr)
                    err_cnt_reg <= ERR_W'(1);
                else if (err_cnt_reg != '1)
                    err_cnt_reg <= err_cnt_reg + 1'b1;
            end else if (err_clr) begin
                err_cnt_reg <= '0;
            end
        end
    end

    assign locked    = locked_reg;
    assign err_pulse = err_pulse_reg;
    assign err_cnt   = err_cnt_reg;

endmodule

// File: tb/tb_lfsr_prbs_checker.sv
// Directed bench for lfsr_prbs_checker. A second instance with a 3-bit
// error counter shares the stimulus to reach counter saturation quickly.
module tb_lfsr_prbs_checker;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        din_bit = 1'b0;
    logic        din_valid = 1'b0;
    logic        err_clr = 1'b0;
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_cnt;
    logic        s_locked;
    logic        s_err_pulse;
    logic [2:0]  s_err_cnt;

    int          tests_run = 0;
    int          tests_failed = 0;
    int          pulse_cnt = 0;
    logic [7:0]  gen = 8'hA5;

    always #5 clk = ~clk;

    lfsr_prbs_checker dut (
        .clk(clk), .resetn(resetn), .din_bit(din_bit), .din_valid(din_valid),
        .err_clr(err_clr), .locked(locked), .err_pulse(err_pulse), .err_cnt(err_cnt)
    );

    lfsr_prbs_checker #(.ERR_W(3)) dut_s (
        .clk(clk), .resetn(resetn), .din_bit(din_bit), .din_valid(din_valid),
        .err_clr(err_clr), .locked(s_locked), .err_pulse(s_err_pulse), .err_cnt(s_err_cnt)
    );

    task automatic step(input logic b, input logic v, input logic clr);
        din_bit = b; din_valid = v; err_clr = clr;
        @(posedge clk); #1;
        if (err_pulse) pulse_cnt++;
    endtask

    task automatic next_gen(output logic b);
        gen = {gen[6:0], gen[3] ^ gen[2] ^ gen[1]};
        b = gen[0];
    endtask

    task automatic send_bit(input logic flip);
        logic b;
        next_gen(b);
        step(b ^ flip, 1'b1, 1'b0);
    endtask

    task automatic send_clean(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b0);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        resetn = 1'b1;
        gen = 8'hA5;
        pulse_cnt = 0;
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if (locked !== 1'b0) begin tests_failed++; $display("FAIL reset_locked: got %0b expected 0", locked); end
        tests_run++;
        if (err_pulse !== 1'b0) begin tests_failed++; $display("FAIL reset_err_pulse: got %0b expected 0", err_pulse); end
        tests_run++;
        if (err_cnt !== 16'd0) begin tests_failed++; $display("FAIL reset_err_cnt: got %0d expected 0", err_cnt); end
        $display("[TB] test_reset done");
    endtask

    task automatic test_clean_lock();
        do_reset();
        send_clean(23);
        tests_run++;
        if (locked !== 1'b0) begin tests_failed++; $display("FAIL lock_early_23: got %0b expected 0", locked); end
        send_clean(1);
        tests_run++;
        if (locked !== 1'b1) begin tests_failed++; $display("FAIL lock_at_24: got %0b expected 1", locked); end
        send_clean(976);
        tests_run++;
        if (err_cnt !== 16'd0) begin tests_failed++; $display("FAIL clean_1000_err_cnt: got %0d expected 0", err_cnt); end
        tests_run++;
        if (pulse_cnt !== 0) begin tests_failed++; $display("FAIL clean_1000_pulses: got %0d expected 0", pulse_cnt); end
        tests_run++;
        if (locked !== 1'b1) begin tests_failed++; $display("FAIL clean_1000_locked: got %0b expected 1", locked); end
        $display("[TB] test_clean_lock done");
    endtask

    task automatic test_single_error();
        send_clean(39);
        send_bit(1'b1);
        tests_run++;
        if (err_pulse !== 1'b1) begin tests_failed++; $display("FAIL single_err_pulse: got %0b expected 1", err_pulse); end
        tests_run++;
        if (err_cnt !== 16'd1) begin tests_failed++; $display("FAIL single_err_cnt: got %0d expected 1", err_cnt); end
        tests_run++;
        if (locked !== 1'b1) begin tests_failed++; $display("FAIL single_err_locked: got %0b expected 1", locked); end
        send_clean(1);
        tests_run++;
        if (err_pulse !== 1'b0) begin tests_failed++; $display("FAIL single_err_pulse_width: got %0b expected 0", err_pulse); end
        tests_run++;
        if (err_cnt !== 16'd1) begin tests_failed++; $display("FAIL single_err_cnt_hold: got %0d expected 1", err_cnt); end
        $display("[TB] test_single_error done");
    endtask

    task automatic test_err_clr();
        logic b;
        step(1'b0, 1'b0, 1'b1);
        tests_run++;
        if (err_cnt !== 16'd0) begin tests_failed++; $display("FAIL clr_idle: got %0d expected 0", err_cnt); end
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        tests_run++;
        if (err_cnt !== 16'd3) begin tests_failed++; $display("FAIL clr_pre_count: got %0d expected 3", err_cnt); end
        next_gen(b);
        step(~b, 1'b1, 1'b1);
        tests_run++;
        if (err_cnt !== 16'd1) begin tests_failed++; $display("FAIL clr_same_cycle_err: got %0d expected 1", err_cnt); end
        tests_run++;
        if (locked !== 1'b1) begin tests_failed++; $display("FAIL clr_locked: got %0b expected 1", locked); end
        $display("[TB] test_err_clr done");
    endtask

    task automatic test_loss_of_lock();
        do_reset();
        send_clean(24);
        for (int i = 0; i < 7; i++) send_bit(1'b1);
        tests_run++;
        if (locked !== 1'b1) begin tests_failed++; $display("FAIL loss_after_7: got %0b expected 1", locked); end
        send_bit(1'b1);
        tests_run++;
        if (locked !== 1'b0) begin tests_failed++; $display("FAIL loss_at_8: got %0b expected 0", locked); end
        tests_run++;
        if (err_cnt !== 16'd8) begin tests_failed++; $display("FAIL loss_err_cnt: got %0d expected 8", err_cnt); end
        send_clean(23);
        tests_run++;
        if (locked !== 1'b0) begin tests_failed++; $display("FAIL relock_early: got %0b expected 0", locked); end
        send_clean(1);
        tests_run++;
        if (locked !== 1'b1) begin tests_failed++; $display("FAIL relock_at_24: got %0b expected 1", locked); end
        tests_run++;
        if (err_cnt !== 16'd8) begin tests_failed++; $display("FAIL relock_err_cnt_kept: got %0d expected 8", err_cnt); end
        $display("[TB] test_loss_of_lock done");
    endtask

    task automatic test_window_wrap_saturation();
        do_reset();
        send_clean(24);
        for (int i = 0; i < 7; i++) send_bit(1'b1);
        tests_run++;
        if (s_err_cnt !== 3'd7) begin tests_failed++; $display("FAIL sat_full: got %0d expected 7", s_err_cnt); end
        send_clean(57);
        send_bit(1'b1);
        tests_run++;
        if (s_err_cnt !== 3'd7) begin tests_failed++; $display("FAIL sat_hold: got %0d expected 7", s_err_cnt); end
        tests_run++;
        if (s_err_pulse !== 1'b1) begin tests_failed++; $display("FAIL sat_pulse: got %0b expected 1", s_err_pulse); end
        tests_run++;
        if (err_cnt !== 16'd8) begin tests_failed++; $display("FAIL wrap_err_cnt: got %0d expected 8", err_cnt); end
        tests_run++;
        if (locked !== 1'b1) begin tests_failed++; $display("FAIL wrap_cleared_window: got %0b expected 1", locked); end
        for (int i = 0; i < 6; i++) send_bit(1'b1);
        tests_run++;
        if (s_locked !== 1'b1) begin tests_failed++; $display("FAIL wrap_7_in_window: got %0b expected 1", s_locked); end
        send_bit(1'b1);
        tests_run++;
        if (locked !== 1'b0) begin tests_failed++; $display("FAIL wrap_8th_loss: got %0b expected 0", locked); end
        $display("[TB] test_window_wrap_saturation done");
    endtask

    task automatic test_all_zero();
        logic seen = 1'b0;
        do_reset();
        for (int i = 0; i < 200; i++) begin
            step(1'b0, 1'b1, 1'b0);
            if (locked) seen = 1'b1;
        end
        tests_run++;
        if (seen !== 1'b0) begin tests_failed++; $display("FAIL zero_never_locks: got %0b expected 0", seen); end
        tests_run++;
        if (err_cnt !== 16'd0) begin tests_failed++; $display("FAIL zero_err_cnt: got %0d expected 0", err_cnt); end
        $display("[TB] test_all_zero done");
    endtask

    task automatic test_valid_toggle();
        int   nvalid = 0;
        int   cycles = 0;
        logic early = 1'b0;
        logic v, b;
        do_reset();
        while (nvalid < 24 && cycles < 1000) begin
            v = 1'($urandom_range(0, 1));
            if (v) begin
                next_gen(b);
                step(b, 1'b1, 1'b0);
                nvalid++;
            end else begin
                step(1'($urandom_range(0, 1)), 1'b0, 1'b0);
            end
            cycles++;
            if (nvalid < 24 && locked) early = 1'b1;
        end
        tests_run++;
        if (nvalid !== 24) begin tests_failed++; $display("FAIL toggle_budget: got %0d valid bits expected 24", nvalid); end
        tests_run++;
        if (early !== 1'b0) begin tests_failed++; $display("FAIL toggle_early_lock: got %0b expected 0", early); end
        tests_run++;
        if (locked !== 1'b1) begin tests_failed++; $display("FAIL toggle_lock: got %0b expected 1", locked); end
        tests_run++;
        if (pulse_cnt !== 0) begin tests_failed++; $display("FAIL toggle_pulses: got %0d expected 0", pulse_cnt); end
        send_bit(1'b1);
        tests_run++;
        if (err_pulse !== 1'b1) begin tests_failed++; $display("FAIL toggle_err_pulse: got %0b expected 1", err_pulse); end
        step(1'b0, 1'b0, 1'b0);
        tests_run++;
        if (err_pulse !== 1'b0) begin tests_failed++; $display("FAIL invalid_pulse_low: got %0b expected 0", err_pulse); end
        tests_run++;
        if (err_cnt !== 16'd1) begin tests_failed++; $display("FAIL toggle_err_cnt: got %0d expected 1", err_cnt); end
        $display("[TB] test_valid_toggle done");
    endtask

    task automatic test_reset_locked();
        logic b;
        do_reset();
        send_clean(24);
        send_bit(1'b1);
        resetn = 1'b0;
        next_gen(b);
        step(~b, 1'b1, 1'b0);
        resetn = 1'b1;
        tests_run++;
        if (locked !== 1'b0) begin tests_failed++; $display("FAIL midreset_locked: got %0b expected 0", locked); end
        tests_run++;
        if (err_pulse !== 1'b0) begin tests_failed++; $display("FAIL midreset_pulse: got %0b expected 0", err_pulse); end
        tests_run++;
        if (err_cnt !== 16'd0) begin tests_failed++; $display("FAIL midreset_err_cnt: got %0d expected 0", err_cnt); end
        $display("[TB] test_reset_locked done");
    endtask

    initial begin
        test_reset();
        test_clean_lock();
        test_single_error();
        test_err_clr();
        test_loss_of_lock();
        test_window_wrap_saturation();
        test_all_zero();
        test_valid_toggle();
        test_reset_locked();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
